// File: rtl/prewitt_stream_ctrl.sv
// prewitt_stream_ctrl: raster-scan sequencer that turns an 8-bit pixel stream
// into one tagged 3x3 window per image position for the Prewitt kernel.
// Two line buffers feed the column taps, and a 3x3 shift register holds the window.
// A single output register stage carries window, centre coordinates and border flag.
// Optional build macro: PREWITT_CTRL_STATS_EN enables the saturating stall counter
// on stall_cycles. When the macro is undefined, stall_cycles is tied to zero.
module prewitt_stream_ctrl #(
  parameter int ROWS = 242,
  parameter int COLS = 247
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [7:0]               in_pixel,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [71:0]              out_window,
  output logic                     out_border,
  output logic [$clog2(ROWS)-1:0]  out_row,
  output logic [$clog2(COLS)-1:0]  out_col,
  output logic                     busy,
  output logic                     frame_done,
  output logic [31:0]              stall_cycles
);

  localparam int RW  = $clog2(ROWS);
  localparam int CW  = $clog2(COLS);
  localparam int LAG = COLS + 1;
  localparam int FW  = $clog2(LAG);

  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [FW-1:0] FILL_LAST = FW'(LAG - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH
  } state_t;

  state_t state;
  state_t state_next;

  logic [RW-1:0] ir;
  logic [CW-1:0] ic;
  logic [FW-1:0] fill_cnt;
  logic [RW-1:0] orow;
  logic [CW-1:0] ocol;
  logic          out_all;

  logic [7:0]    linebuf0 [COLS];
  logic [7:0]    linebuf1 [COLS];

  logic [71:0]   win;
  logic [71:0]   win_next;

  logic          slot_free;
  logic          accept;
  logic          in_last;
  logic          load_out;
  logic          done_hs;
  logic          frame_start;

  // Handshake decode and next-state selection
  always_comb begin
    state_next  = state;
    slot_free   = !out_valid || out_ready;
    in_ready    = ((state == FILL) || (state == RUN)) && slot_free;
    accept      = in_valid && in_ready;
    in_last     = (ir == ROW_LAST) && (ic == COL_LAST);
    frame_start = (state == IDLE) && start;
    busy        = (state != IDLE);
    // Output slot is loaded once per accepted pixel in RUN, or freely in FLUSH
    // until the final window has been placed.
    load_out    = ((state == RUN) && accept) ||
                  ((state == FLUSH) && slot_free && !out_all);
    done_hs     = (state == FLUSH) && out_all && out_valid && out_ready;
    case (state)
      IDLE:    if (start) state_next = FILL;
      FILL:    if (accept && (fill_cnt == FILL_LAST)) state_next = RUN;
      RUN:     if (accept && in_last) state_next = FLUSH;
      FLUSH:   if (done_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Window after shifting left one column and inserting the new column taps
  always_comb begin
    win_next = win;
    for (int unsigned r = 0; r < 3; r++) begin
      win_next[(r*3)*8   +: 8] = win[(r*3+1)*8 +: 8];
      win_next[(r*3+1)*8 +: 8] = win[(r*3+2)*8 +: 8];
    end
    win_next[2*8 +: 8] = linebuf1[ic];
    win_next[5*8 +: 8] = linebuf0[ic];
    win_next[8*8 +: 8] = in_pixel;
  end

  // Input raster counters, fill counter and window shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir       <= '0;
      ic       <= '0;
      fill_cnt <= '0;
      win      <= '0;
    end else if (frame_start) begin
      ir       <= '0;
      ic       <= '0;
      fill_cnt <= '0;
    end else if (accept) begin
      win <= win_next;
      if (ic == COL_LAST) begin
        ic <= '0;
        ir <= ir + 1'b1;
      end else begin
        ic <= ic + 1'b1;
      end
      if (state == FILL) fill_cnt <= fill_cnt + 1'b1;
    end
  end

  // Line buffers: previous two rows at the current column (not reset)
  always_ff @(posedge clk) begin
    if (accept) begin
      linebuf1[ic] <= linebuf0[ic];
      linebuf0[ic] <= in_pixel;
    end
  end

  // Output register stage with centre coordinates and border tag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_window <= '0;
      out_border <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
      orow       <= '0;
      ocol       <= '0;
      out_all    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= done_hs;
      if (frame_start) begin
        orow    <= '0;
        ocol    <= '0;
        out_all <= 1'b0;
      end
      if (load_out) begin
        out_valid  <= 1'b1;
        out_window <= win_next;
        out_row    <= orow;
        out_col    <= ocol;
        out_border <= (orow == '0) || (orow == ROW_LAST) ||
                      (ocol == '0) || (ocol == COL_LAST);
        if (ocol == COL_LAST) begin
          ocol <= '0;
          orow <= orow + 1'b1;
        end else begin
          ocol <= ocol + 1'b1;
        end
        if ((orow == ROW_LAST) && (ocol == COL_LAST)) out_all <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef PREWITT_CTRL_STATS_EN
  // Saturating count of cycles where a window waits on downstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (frame_start) begin
      stall_cycles <= '0;
    end else if (out_valid && !out_ready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end
`else
  // Statistics not built
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_prewitt_stream_ctrl.sv
// tb_prewitt_stream_ctrl: randomized stream bench for prewitt_stream_ctrl using a
// small 4x5 image. Expected windows come from direct image indexing around each centre.
module tb_prewitt_stream_ctrl;

  localparam int ROWS = 4;
  localparam int COLS = 5;
  localparam int N    = ROWS * COLS;
  localparam int LAG  = COLS + 1;
  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(COLS);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_pixel = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [71:0]   out_window;
  logic          out_border;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          busy;
  logic          frame_done;
  logic [31:0]   stall_cycles;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] img [N];
  int n_in, n_out, n_done, n_stall;
  bit busy_exp, done_exp;

  always #5 clk = ~clk;

  prewitt_stream_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_pixel(in_pixel), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_window(out_window),
    .out_border(out_border), .out_row(out_row), .out_col(out_col),
    .busy(busy), .frame_done(frame_done), .stall_cycles(stall_cycles)
  );

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_border(input int k);
    int r = k / COLS;
    int c = k % COLS;
    return (r == 0) || (r == ROWS-1) || (c == 0) || (c == COLS-1);
  endfunction

  function automatic logic [71:0] ref_window(input int k);
    int r = k / COLS;
    int c = k % COLS;
    logic [71:0] w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(i*3+j)*8 +: 8] = img[(r-1+i)*COLS + (c-1+j)];
    return w;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},   in_ready,     0);
    check({tag, "_out_valid"},  out_valid,    0);
    check({tag, "_out_window"}, out_window,   0);
    check({tag, "_out_border"}, out_border,   0);
    check({tag, "_out_row"},    out_row,      0);
    check({tag, "_out_col"},    out_col,      0);
    check({tag, "_busy"},       busy,         0);
    check({tag, "_frame_done"}, frame_done,   0);
    check({tag, "_stall"},      stall_cycles, 0);
  endtask

  // One clock: observe at negedge against the model, then drive just after posedge
  task automatic step(input int v_pct, input int r_mode);
    bit in_acc, out_acc, was_busy;
    int k;
    @(negedge clk);
    was_busy = busy_exp;
    check("busy", busy, busy_exp);
    check("frame_done", frame_done, done_exp);
    in_acc  = in_valid && in_ready;
    out_acc = out_valid && out_ready;
    if (busy_exp && (n_in < N)) check("out_valid_run", out_valid, (n_in > LAG + n_out));
    if (!busy_exp || (n_in >= N)) check("in_ready_blocked", in_ready, 0);
    if (out_valid && !out_ready) begin
      check("in_ready_stall", in_ready, 0);
      n_stall++;
    end
    if (out_acc) begin
      if (n_out >= N) begin
        check("extra_window", out_valid, 0);
      end else begin
        k = n_out;
        check("row", out_row, k / COLS);
        check("col", out_col, k % COLS);
        check("border", out_border, ref_border(k));
        if (!ref_border(k)) check("window", out_window, ref_window(k));
        n_out++;
      end
    end
    if (in_acc) n_in++;
    done_exp = 1'b0;
    if (out_acc && (n_out == N) && busy_exp) begin
      busy_exp = 1'b0;
      done_exp = 1'b1;
      n_done++;
    end
    if (start && !was_busy) begin
      busy_exp = 1'b1;
      n_stall  = 0;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    if (n_in < N) begin
      in_valid = ($urandom_range(99) < v_pct);
      in_pixel = img[n_in];
    end else begin
      in_valid = 1'($urandom_range(1));
      in_pixel = 8'($urandom);
    end
    if (r_mode < 0) out_ready = !out_ready;
    else            out_ready = ($urandom_range(99) < r_mode);
  endtask

  // Run one frame; rst_after > 0 stops feeding once that many inputs are accepted
  task automatic run_frame(input bit seq, input int v_pct, input int r_mode,
                           input bit start_mid, input int rst_after);
    int cyc = 0;
    bit pulsed = 1'b0;
    for (int i = 0; i < N; i++) img[i] = seq ? 8'(i) : 8'($urandom);
    n_in = 0; n_out = 0; n_done = 0; n_stall = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    start     = 1'b1;
    while (!((n_done > 0) && !busy_exp) && (cyc < 3000)) begin
      if ((rst_after > 0) && (n_in >= rst_after)) return;
      if (start_mid && !pulsed && (n_in == 10)) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      step(v_pct, r_mode);
      cyc++;
    end
    for (int i = 0; i < 3; i++) step(50, 50);
    check("windows_total", n_out, N);
    check("frame_done_count", n_done, 1);
`ifdef PREWITT_CTRL_STATS_EN
    check("stall_cycles", stall_cycles, n_stall);
`else
    check("stall_cycles", stall_cycles, 0);
`endif
  endtask

  initial begin
    busy_exp = 1'b0;
    done_exp = 1'b0;
    #1 rst = 1'b1;
    #2 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step(0, 100);

    // sequential image, full throughput
    run_frame(1'b1, 100, 100, 1'b0, 0);
    // sequential image, downstream ready toggling every cycle
    run_frame(1'b1, 100, -1, 1'b0, 0);

    // abort mid-frame with reset, then a clean frame
    run_frame(1'b1, 100, 100, 1'b0, 10);
    #2 rst = 1'b1;
    #1 check_reset_outputs("abort");
    @(posedge clk);
    #1 rst = 1'b0;
    busy_exp = 1'b0;
    done_exp = 1'b0;
    in_valid = 1'b0;
    step(0, 100);
    run_frame(1'b1, 100, 100, 1'b0, 0);

    // start pulse during RUN is ignored
    run_frame(1'b0, 70, 70, 1'b1, 0);

    // random images with random valid gaps and back-pressure
    for (int f = 0; f < 4; f++) run_frame(1'b0, 60, 60, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
